// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler driving the select of a 1:8 demux, with bounded bursts
// per grant and the demultiplexed one-hot data word as an output.
module demux_rr_scheduler #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       i,
    output logic [2:0] s,
    output logic [7:0] grant,
    output logic       valid,
    output logic [7:0] y
);

    localparam int unsigned      HoldEff = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(HoldEff - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       ptr;
    logic [2:0]       next_ptr;
    logic [3:0]       win_idle;
    logic [3:0]       win_rel;
    logic             release_now;

    // Returns {found, index} of the first set request at or after base, wrapping mod 8.
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int k = 7; k >= 0; k--) begin
            idx = base + 3'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign next_ptr    = s + 3'd1;
    assign release_now = (cnt == '0) || !req[s] || !en;

    always_comb begin
        win_idle = pick(req, ptr);
        win_rel  = pick(req, next_ptr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            s     <= '0;
            grant <= '0;
            valid <= 1'b0;
            cnt   <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (en && win_idle[3]) begin
                        state <= StGrant;
                        s     <= win_idle[2:0];
                        grant <= 8'd1 << win_idle[2:0];
                        valid <= 1'b1;
                        cnt   <= CntLoad;
                    end
                end
                StGrant: begin
                    if (!release_now) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Served channel drops to lowest priority but stays eligible.
                        ptr <= next_ptr;
                        if (en && win_rel[3]) begin
                            s     <= win_rel[2:0];
                            grant <= 8'd1 << win_rel[2:0];
                            cnt   <= CntLoad;
                        end else begin
                            state <= StIdle;
                            grant <= '0;
                            valid <= 1'b0;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        y = '0;
        if (valid && i) begin
            y = 8'd1 << s;
        end
    end

endmodule

// File: doc/demux_rr_scheduler.md
Name: demux_rr_scheduler

Overview:
Round-robin scheduler that shares one serial data line among 8 destination channels by driving the 3-bit select of a 1:8 demultiplexer. Destinations raise request bits. The block grants one channel at a time for a bounded burst, then rotates priority. It also outputs the demultiplexed one-hot data word, so it sits directly between the serial source and the 8 channel sinks.

Parameters:
HOLD_CYCLES, 4, maximum cycles per grant (legal 1..255; 0 is treated as 1)
CNT_W, 8, width of the burst counter; must hold HOLD_CYCLES-1

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
en  input  1  scheduler enable; low blocks new grants and ends the current grant
req  input  8  per-channel request, bit k = channel k
i  input  1  serial data to route
s  output  3  demux select; index of the granted channel
grant  output  8  one-hot grant; all zero when idle
valid  output  1  high while a grant is active
y  output  8  demuxed data: y[s] = i when valid=1, all other bits 0

Behaviour:
- Single clock domain. All state updates on the rising edge of clk.
- rst asserts asynchronously. It sets state=IDLE, s=0, grant=0, valid=0, cnt=0, ptr=0 (the priority pointer). y then becomes 0 combinationally.
- y is combinational:
  - valid=1 and i=1: y = 8'b1 << s.
  - Otherwise: y = 0.
- Winner selection:
  - Search req starting at index ptr, then ptr+1, and so on, wrapping mod 8.
  - The first set bit wins.
  - If req=0, there is no winner.
- State IDLE:
  - en=1 and req!=0 at a rising edge: the next cycle enters GRANT with s=winner, grant=1<<winner, valid=1, cnt=HOLD_CYCLES-1.
  - Latency from sampled request to valid grant is 1 cycle.
  - en=0 or req=0: stay in IDLE; outputs are unchanged.
- State GRANT, release condition at each rising edge: any of cnt==0, req[s]==0, en==0.
  - No release: cnt decrements; s, grant and valid hold.
  - On release: ptr <= (s+1) mod 8, so the just-served channel has the lowest priority.
  - Release with en=1 and another winner, searching from the new ptr (the served channel is still eligible, last): back-to-back grant with no idle cycle. s and grant update, valid stays 1, cnt is reloaded.
  - Release with no winner, or en=0: go to IDLE. valid=0, grant=0, s holds its last value.
- Burst length: a channel holding its request continuously gets exactly HOLD_CYCLES valid cycles per grant. HOLD_CYCLES=1 gives per-cycle rotation.
- Changes to req bits of non-granted channels during a grant have no effect until the next selection.
- Wrap-around: ptr=7 with req=8'b0000_0100 grants channel 2. After serving channel 7, ptr wraps to 0.
- grant is always either zero or one-hot, and valid == |grant.
- Reset mid-grant: outputs clear immediately, without waiting for clk. After reset is released, the next grant follows ptr=0 ordering.

Test Plan:
- Reset then single request: req=8'h08, en=1, HOLD_CYCLES=4. Response: one cycle later s=3, grant=8'h08, valid=1 for exactly 4 cycles. Then 4 more cycles of grant with no idle gap. Drop req, and valid=0 the cycle after release.
- Full contention: req=8'hFF held, HOLD_CYCLES=2. Response: grants run 0,1,2,...,7,0 with 2 cycles each, back-to-back, and valid never drops.
- Early release and wrap: ptr at 6 via a prior grant of channel 5. req=8'h44. Response: channel 6 is granted. Clear req[6] after 1 cycle; channel 2 is granted on the next cycle (wrap past 7).
- Data routing: grant on channel 5, drive i=1,0,1. Response: y=8'h20,8'h00,8'h20. While idle with i=1, y=8'h00.
- Enable control: deassert en mid-grant. Response: IDLE next cycle with valid=0, and no new grant while en=0 even with req=8'hFF. Reassert en and a grant starts 1 cycle later from the updated ptr.
- Asynchronous reset mid-burst: assert rst between clock edges during a grant. Response: grant=0, valid=0, s=0, y=0 immediately. After release with req=8'h81, channel 0 is granted first.
